clock_tick_extractor: RTL and testbench

Consumer side of the free-running divided-clock bus. Selects one bit of `divided_clocks`, resynchronises it, and turns each rising edge into a single-cycle `tick` enable, so downstream FSMs run on the fast `clock` instead of clocking off divided bits. It also measures the selected bit's period in `clock` cycles and flags when that measurement is valid. It sits between the clock divider and any game/display logic that needs slow enables.

---
 rtl/clock_tick_extractor.sv | 139 +++++++++++++
 tb/tb_clock_tick_extractor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/clock_tick_extractor.sv
// rtl/clock_tick_extractor.sv - divided-clock bit selector, resync, rising-edge tick and period meter
module clock_tick_extractor #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         divided_clocks,
  input  logic [$clog2(WIDTH)-1:0] sel,
  output logic                     tick,
  output logic [PERIOD_W-1:0]      period,
  output logic                     period_valid,
  output logic                     sel_busy
);
  localparam int SEL_W = $clog2(WIDTH);
  localparam int SET_W = $clog2(SYNC_STAGES + 2);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {ST_SETTLE, ST_ARM, ST_TRACK} state_t;

  state_t                 state_q, state_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [PERIOD_W-1:0]    cnt_q, cnt_d;
  logic                   tick_q, tick_d;
  logic [PERIOD_W-1:0]    period_q, period_d;
  logic                   valid_q, valid_d;

  logic sel_bit;
  logic sel_changed;
  logic edge_seen;

  // Indices at or beyond WIDTH fall through the loop and read as 0.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_q == SEL_W'(i)) sel_bit = divided_clocks[i];
    end
  end

  assign sel_changed = (sel != sel_q);
  assign edge_seen   = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_SETTLE;
      settle_q <= SETTLE_LOAD;
      sel_q    <= sel;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      period_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      sel_q    <= sel_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      period_q <= period_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (sel_changed) begin
      state_d  = ST_SETTLE;
      settle_d = SETTLE_LOAD;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          settle_d = settle_q - 1'b1;
          if (settle_q <= SET_W'(1)) state_d = ST_ARM;
        end
        ST_ARM:   if (edge_seen) state_d = ST_TRACK;
        ST_TRACK: state_d = ST_TRACK;
        default:  begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
        end
      endcase
    end
  end

  // prev follows the chain every cycle, so it already holds the settled level when ARM starts.
  always_comb begin
    sel_d     = sel;
    sync_d    = '0;
    sync_d[0] = sel_bit;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d   = sync_q[SYNC_STAGES-1];
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    period_d = period_q;
    valid_d  = valid_q;
    if (sel_changed) begin
      sync_d  = '0;
      prev_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ARM: begin
          if (edge_seen) begin
            tick_d = 1'b1;
            cnt_d  = PERIOD_W'(1);
          end
        end
        ST_TRACK: begin
          cnt_d = (cnt_q == {PERIOD_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          if (edge_seen) begin
            tick_d   = 1'b1;
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = PERIOD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tick         = tick_q;
    period       = period_q;
    period_valid = valid_q;
    sel_busy     = (state_q == ST_SETTLE);
  end

endmodule

// File: tb/tb_clock_tick_extractor.sv
// tb/tb_clock_tick_extractor.sv - randomized check of clock_tick_extractor against a sample-history model
module tb_clock_tick_extractor;
  localparam int W     = 24;
  localparam int S     = 2;
  localparam int SEL_W = $clog2(W);
  localparam int HMAX  = 8192;

  logic             clock;
  logic             reset;
  logic [W-1:0]     divided_clocks;
  logic [SEL_W-1:0] sel;

  logic        tick_a, valid_a, busy_a;
  logic [31:0] period_a;
  logic        tick_b, valid_b, busy_b;
  logic [3:0]  period_b;

  clock_tick_extractor #(.WIDTH(W), .SYNC_STAGES(S), .PERIOD_W(32)) u_dut (
    .clock          (clock),
    .reset          (reset),
    .divided_clocks (divided_clocks),
    .sel            (sel),
    .tick           (tick_a),
    .period         (period_a),
    .period_valid   (valid_a),
    .sel_busy       (busy_a)
  );

  clock_tick_extractor #(.WIDTH(W), .SYNC_STAGES(S), .PERIOD_W(4)) u_sat (
    .clock          (clock),
    .reset          (reset),
    .divided_clocks (divided_clocks),
    .sel            (sel),
    .tick           (tick_b),
    .period         (period_b),
    .period_valid   (valid_b),
    .sel_busy       (busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: the selected bit sampled at each edge, with the last clear edge
  // (reset or sel change) and the last tick since that clear.
  bit               hist [0:HMAX-1];
  int               n = 0;
  int               clr = 0;
  int               last_tick = -1;
  logic [SEL_W-1:0] m_sel = '0;
  logic             m_tick = 1'b0;
  logic             m_valid = 1'b0;
  longint           m_period = 0;
  logic [31:0]      dc = '0;
  int               tick_cnt = 0;

  function automatic longint sat(input longint v, input int bits);
    longint mx;
    mx = (longint'(1) << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge(input logic rst_in, input logic [SEL_W-1:0] sel_in, input logic [W-1:0] dcv);
    n++;
    if (!rst_in || sel_in != m_sel) begin
      clr       = n;
      m_sel     = sel_in;
      m_tick    = 1'b0;
      m_valid   = 1'b0;
      last_tick = -1;
      hist[n]   = 1'b0;
      if (!rst_in) m_period = 0;
    end else begin
      hist[n] = (int'(m_sel) < W) ? dcv[m_sel] : 1'b0;
      m_tick  = (n >= clr + S + 2) && hist[n-S] && !hist[n-S-1];
      if (m_tick) begin
        if (last_tick >= 0) begin
          m_period = n - last_tick;
          m_valid  = 1'b1;
        end
        last_tick = n;
      end
    end
  endtask

  task automatic cycle(input logic rst_in, input logic [SEL_W-1:0] sel_in);
    logic busy_exp;
    reset          = rst_in;
    sel            = sel_in;
    divided_clocks = dc[W-1:0];
    @(posedge clock);
    model_edge(rst_in, sel_in, dc[W-1:0]);
    dc++;
    @(negedge clock);
    busy_exp = (n <= clr + S);
    check("tick",      tick_a,   m_tick);
    check("period",    period_a, sat(m_period, 32));
    check("valid",     valid_a,  m_valid);
    check("busy",      busy_a,   busy_exp);
    check("tick_w4",   tick_b,   m_tick);
    check("period_w4", period_b, sat(m_period, 4));
    check("valid_w4",  valid_b,  m_valid);
    check("busy_w4",   busy_b,   busy_exp);
    if (tick_a) tick_cnt++;
  endtask

  initial begin
    int r;
    int len;
    logic [SEL_W-1:0] s_new;

    reset = 1'b0;
    sel = SEL_W'(1);
    divided_clocks = '0;

    for (int i = 0; i < 3; i++) cycle(1'b0, SEL_W'(1));
    check("rst_period", period_a, 64'd0);
    check("rst_busy",   busy_a,   64'd1);

    for (int i = 0; i < 20; i++) cycle(1'b1, SEL_W'(1));
    check("sel1_period", period_a, 64'd4);
    check("sel1_valid",  valid_a,  64'd1);

    for (int i = 0; i < 50; i++) cycle(1'b1, SEL_W'(3));
    check("sel3_period", period_a, 64'd16);

    for (int i = 0; i < 20; i++) cycle(1'b1, SEL_W'(0));
    check("sel0_period", period_a, 64'd2);

    for (int i = 0; i < 100; i++) cycle(1'b1, SEL_W'(4));
    check("sel4_period",    period_a, 64'd32);
    check("sat_period_w4",  period_b, 64'd15);
    check("sat_valid_w4",   valid_b,  64'd1);

    tick_cnt = 0;
    for (int i = 0; i < 100; i++) cycle(1'b1, SEL_W'(W));
    check("oor_ticks", tick_cnt, 64'd0);
    check("oor_valid", valid_a,  64'd0);

    for (int i = 0; i < 30; i++) cycle(1'b1, SEL_W'(2));
    check("sel2_valid", valid_a, 64'd1);
    cycle(1'b0, SEL_W'(2));
    check("midrst_period", period_a, 64'd0);
    check("midrst_valid",  valid_a,  64'd0);
    check("midrst_busy",   busy_a,   64'd1);

    for (int seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 9);
      s_new = (r < 8) ? SEL_W'(r % 6) : SEL_W'(W + $urandom_range(0, (1 << SEL_W) - W - 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 80);
      for (int i = 0; i < len; i++) begin
        cycle(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, s_new);
      end
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
